// File: rtl/axi4_lite_sram_slave_if.sv
// AXI4-Lite channel bundle between the SRAM-to-AXI-Lite bridge (master)
// and the on-chip SRAM slave.
// Channels: ar (read address), aw (write address), rd (read data),
//           wd (write data + wstrb), wr (write response, wr_breap 1 = OKAY).
interface axi4_lite_sram_slave_if #(
    parameter int unsigned BUS_WIDTH  = 32,
    parameter int unsigned DATA_WIDTH = 32
);
    logic                      ar_valid;
    logic                      ar_ready;
    logic [BUS_WIDTH-1:0]      ar_addr;
    logic [2:0]                ar_prot;

    logic                      aw_valid;
    logic                      aw_ready;
    logic [BUS_WIDTH-1:0]      aw_addr;
    logic [2:0]                aw_prot;

    logic                      rd_valid;
    logic                      rd_ready;
    logic [DATA_WIDTH-1:0]     rd_data;

    logic                      wd_valid;
    logic                      wd_ready;
    logic [DATA_WIDTH-1:0]     wd_data;
    logic [DATA_WIDTH/8-1:0]   wstrb;

    logic                      wr_valid;
    logic                      wr_ready;
    logic                      wr_breap;

    modport master (
        output ar_valid, ar_addr, ar_prot,
        output aw_valid, aw_addr, aw_prot,
        output rd_ready,
        output wd_valid, wd_data, wstrb,
        output wr_ready,
        input  ar_ready, aw_ready, rd_valid, rd_data, wd_ready, wr_valid, wr_breap
    );

    modport slave (
        input  ar_valid, ar_addr, ar_prot,
        input  aw_valid, aw_addr, aw_prot,
        input  rd_ready,
        input  wd_valid, wd_data, wstrb,
        input  wr_ready,
        output ar_ready, aw_ready, rd_valid, rd_data, wd_ready, wr_valid, wr_breap
    );
endinterface

// File: rtl/axi4_lite_sram_slave.sv
// AXI4-Lite slave serving one read or write at a time from a word-organised
// on-chip SRAM with byte-lane write enables.
// Ports: aclk (rising edge), reset (synchronous, active-high),
//        bus (axi4_lite_sram_slave_if.slave: ar/aw/rd/wd/wr channels).
// Ready outputs are combinational from state and the *_got flags; valid,
// data and response outputs are registered.
module axi4_lite_sram_slave #(
    parameter int unsigned          BUS_WIDTH  = 32,
    parameter int unsigned          DATA_WIDTH = 32,
    parameter int unsigned          DEPTH      = 1024,
    parameter logic [BUS_WIDTH-1:0] BASE_ADDR  = BUS_WIDTH'(32'h8000_0000)
) (
    input logic                   aclk,
    input logic                   reset,
    axi4_lite_sram_slave_if.slave bus
);
    localparam int unsigned          IDX_W  = $clog2(DEPTH);
    localparam int unsigned          STRB_W = DATA_WIDTH / 8;
    localparam logic [BUS_WIDTH-1:0] SPAN   = BUS_WIDTH'(DEPTH * 4);

    typedef enum logic [1:0] {IDLE, RRESP, WCOLLECT, WRESP} state_t;

    state_t                state;
    logic [DATA_WIDTH-1:0] mem [DEPTH];

    logic                  aw_got, wd_got;
    logic [BUS_WIDTH-1:0]  aw_addr_q;
    logic [DATA_WIDTH-1:0] wd_data_q;
    logic [STRB_W-1:0]     wstrb_q;

    logic                  rd_valid, wr_valid, wr_breap;
    logic [DATA_WIDTH-1:0] rd_data;
    logic                  ar_ready, aw_ready, wd_ready;

    logic                  ar_hs, aw_hs, wd_hs, commit, mem_we;
    logic [BUS_WIDTH-1:0]  r_off, w_off, w_addr;
    logic [DATA_WIDTH-1:0] w_data;
    logic [STRB_W-1:0]     w_strb;
    logic                  r_in_range, w_in_range;
    logic                  unused_prot;

    assign unused_prot = ^{bus.ar_prot, bus.aw_prot};

    // Ready generation; writes win over a simultaneous read in IDLE.
    always_comb begin
        ar_ready = 1'b0;
        aw_ready = 1'b0;
        wd_ready = 1'b0;
        case (state)
            IDLE: begin
                aw_ready = 1'b1;
                wd_ready = 1'b1;
                ar_ready = ~bus.aw_valid & ~bus.wd_valid;
            end
            WCOLLECT: begin
                aw_ready = ~aw_got;
                wd_ready = ~wd_got;
            end
            default: ;
        endcase
    end

    assign ar_hs = bus.ar_valid & ar_ready;
    assign aw_hs = bus.aw_valid & aw_ready;
    assign wd_hs = bus.wd_valid & wd_ready;

    // Effective write payload: captured half if already held, else live bus.
    assign w_addr = aw_got ? aw_addr_q : bus.aw_addr;
    assign w_data = wd_got ? wd_data_q : bus.wd_data;
    assign w_strb = wd_got ? wstrb_q   : bus.wstrb;

    // Offsets wrap for addresses below the base, which lands them out of range.
    assign r_off      = bus.ar_addr - BASE_ADDR;
    assign w_off      = w_addr - BASE_ADDR;
    assign r_in_range = r_off < SPAN;
    assign w_in_range = w_off < SPAN;

    assign commit = ((state == IDLE) || (state == WCOLLECT))
                    & (aw_got | aw_hs) & (wd_got | wd_hs);
    assign mem_we = commit & w_in_range & ~reset;

    // Byte-lane memory write; contents survive reset.
    always_ff @(posedge aclk) begin
        if (mem_we) begin
            for (int i = 0; i < int'(STRB_W); i++) begin
                if (w_strb[i]) begin
                    mem[w_off[2 +: IDX_W]][8*i +: 8] <= w_data[8*i +: 8];
                end
            end
        end
    end

    // Transaction FSM with registered response channels.
    always_ff @(posedge aclk) begin
        if (reset) begin
            state    <= IDLE;
            aw_got   <= 1'b0;
            wd_got   <= 1'b0;
            rd_valid <= 1'b0;
            rd_data  <= '0;
            wr_valid <= 1'b0;
            wr_breap <= 1'b0;
        end else begin
            case (state)
                IDLE, WCOLLECT: begin
                    if (aw_hs) begin
                        aw_got    <= 1'b1;
                        aw_addr_q <= bus.aw_addr;
                    end
                    if (wd_hs) begin
                        wd_got    <= 1'b1;
                        wd_data_q <= bus.wd_data;
                        wstrb_q   <= bus.wstrb;
                    end
                    if (commit) begin
                        state    <= WRESP;
                        wr_valid <= 1'b1;
                        wr_breap <= w_in_range;
                    end else if (ar_hs) begin
                        state    <= RRESP;
                        rd_valid <= 1'b1;
                        rd_data  <= r_in_range ? mem[r_off[2 +: IDX_W]] : '0;
                    end else if (aw_hs | wd_hs) begin
                        state <= WCOLLECT;
                    end
                end
                RRESP: begin
                    if (bus.rd_ready) begin
                        state    <= IDLE;
                        rd_valid <= 1'b0;
                        rd_data  <= '0;
                    end
                end
                WRESP: begin
                    if (bus.wr_ready) begin
                        state    <= IDLE;
                        wr_valid <= 1'b0;
                        wr_breap <= 1'b0;
                        aw_got   <= 1'b0;
                        wd_got   <= 1'b0;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

    assign bus.ar_ready = ar_ready;
    assign bus.aw_ready = aw_ready;
    assign bus.wd_ready = wd_ready;
    assign bus.rd_valid = rd_valid;
    assign bus.rd_data  = rd_data;
    assign bus.wr_valid = wr_valid;
    assign bus.wr_breap = wr_breap;
endmodule

// File: tb/tb_axi4_lite_sram_slave.sv
// Self-checking bench for axi4_lite_sram_slave: a vector table of reads and
// writes with hand-derived expectations, scoreboard queues popped by a
// response monitor, and hand sequences for split writes, priority,
// backpressure and mid-transaction reset.
module tb_axi4_lite_sram_slave;
    logic aclk = 1'b0;
    logic reset;

    always #5 aclk = ~aclk;

    axi4_lite_sram_slave_if #(.BUS_WIDTH(32), .DATA_WIDTH(32)) bus ();

    axi4_lite_sram_slave #(
        .BUS_WIDTH (32),
        .DATA_WIDTH(32),
        .DEPTH     (1024),
        .BASE_ADDR (32'h8000_0000)
    ) dut (
        .aclk (aclk),
        .reset(reset),
        .bus  (bus)
    );

    typedef struct {
        bit          wr;
        logic [31:0] addr;
        logic [31:0] data;
        logic [3:0]  strb;
        int          aw_d;
        int          wd_d;
        int          hold;
        logic [31:0] exp;
    } vec_t;

    int total = 0;
    int bad   = 0;
    logic [31:0] rq[$];
    logic [31:0] wq[$];

    task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %h want %h", nm, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge aclk);
        #1;
    endtask

    // Response monitor: pops the scoreboard when a response handshakes.
    always @(negedge aclk) begin
        if (reset === 1'b0) begin
            if (bus.rd_valid === 1'b1 && bus.rd_ready === 1'b1) begin
                if (rq.size() == 0) check("rd_unexpected", 32'd1, 32'd0);
                else check("rd_data", bus.rd_data, rq.pop_front());
            end
            if (bus.wr_valid === 1'b1 && bus.wr_ready === 1'b1) begin
                if (wq.size() == 0) check("wr_unexpected", 32'd1, 32'd0);
                else check("wr_breap", {31'b0, bus.wr_breap}, wq.pop_front());
            end
        end
    end

    task automatic do_write(input logic [31:0] a, input logic [31:0] d, input logic [3:0] s,
                            input int aw_d, input int wd_d, input logic [31:0] exp);
        bit aw_done = 0;
        bit wd_done = 0;
        int c = 0;
        wq.push_back(exp);
        while (!(aw_done && wd_done)) begin
            bus.aw_valid = !aw_done && (c >= aw_d);
            bus.aw_addr  = a;
            bus.wd_valid = !wd_done && (c >= wd_d);
            bus.wd_data  = d;
            bus.wstrb    = s;
            @(negedge aclk);
            check("wr_early", {31'b0, bus.wr_valid}, 32'd0);
            if (bus.aw_valid && bus.aw_ready) aw_done = 1;
            if (bus.wd_valid && bus.wd_ready) wd_done = 1;
            tick();
            c++;
            if (c > 50) begin
                check("wr_timeout", 32'd1, 32'd0);
                break;
            end
        end
        bus.aw_valid = 1'b0;
        bus.wd_valid = 1'b0;
        @(negedge aclk);
        check("wr_latency", {31'b0, bus.wr_valid}, 32'd1);
        tick();
    endtask

    task automatic do_read(input logic [31:0] a, input logic [31:0] exp, input int hold);
        bit hs;
        int c = 0;
        rq.push_back(exp);
        bus.rd_ready = (hold == 0);
        bus.ar_valid = 1'b1;
        bus.ar_addr  = a;
        forever begin
            @(negedge aclk);
            hs = bus.ar_ready;
            tick();
            if (hs) break;
            if (++c > 50) begin
                check("ar_timeout", 32'd1, 32'd0);
                break;
            end
        end
        bus.ar_valid = 1'b0;
        for (int i = 0; i < hold; i++) begin
            @(negedge aclk);
            check("bp_rd_valid", {31'b0, bus.rd_valid}, 32'd1);
            check("bp_rd_data", bus.rd_data, exp);
            check("bp_ar_ready", {31'b0, bus.ar_ready}, 32'd0);
            check("bp_aw_ready", {31'b0, bus.aw_ready}, 32'd0);
            tick();
        end
        bus.rd_ready = 1'b1;
        @(negedge aclk);
        check("rd_latency", {31'b0, bus.rd_valid}, 32'd1);
        tick();
    endtask

    // One half in cycle 1, the other in cycle 4; wr_valid must rise in cycle 5.
    task automatic split_write(input logic [31:0] a, input logic [31:0] d, input bit aw_first);
        wq.push_back(32'd1);
        bus.aw_addr = a;
        bus.wd_data = d;
        bus.wstrb   = 4'hF;
        if (aw_first) bus.aw_valid = 1'b1; else bus.wd_valid = 1'b1;
        @(negedge aclk);
        tick();
        bus.aw_valid = 1'b0;
        bus.wd_valid = 1'b0;
        for (int k = 2; k <= 4; k++) begin
            if (k == 4) begin
                if (aw_first) bus.wd_valid = 1'b1; else bus.aw_valid = 1'b1;
            end
            @(negedge aclk);
            if (aw_first) check("split_aw_ready", {31'b0, bus.aw_ready}, 32'd0);
            else          check("split_wd_ready", {31'b0, bus.wd_ready}, 32'd0);
            check("split_wr_low", {31'b0, bus.wr_valid}, 32'd0);
            tick();
        end
        bus.aw_valid = 1'b0;
        bus.wd_valid = 1'b0;
        @(negedge aclk);
        check("split_wr_rise", {31'b0, bus.wr_valid}, 32'd1);
        tick();
    endtask

    vec_t vt[18];

    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    initial begin
        vt = '{
            '{1, 32'h8000_0010, 32'hCAFE_F00D, 4'hF, 0, 0, 0, 32'd1},
            '{0, 32'h8000_0010, 32'h0,         4'h0, 0, 0, 0, 32'hCAFE_F00D},
            '{1, 32'h8000_0020, 32'h1122_3344, 4'hF, 0, 0, 0, 32'd1},
            '{1, 32'h8000_0020, 32'hAABB_CCDD, 4'h5, 0, 2, 0, 32'd1},
            '{0, 32'h8000_0020, 32'h0,         4'h0, 0, 0, 0, 32'h11BB_33DD},
            '{1, 32'h8000_0020, 32'h9988_7766, 4'hA, 1, 0, 0, 32'd1},
            '{0, 32'h8000_0020, 32'h0,         4'h0, 0, 0, 0, 32'h99BB_77DD},
            '{1, 32'h8000_0000, 32'h5A5A_5A5A, 4'hF, 3, 0, 0, 32'd1},
            '{1, 32'h8000_1000, 32'hDEAD_BEEF, 4'hF, 0, 0, 0, 32'd0},
            '{0, 32'h8000_1000, 32'h0,         4'h0, 0, 0, 0, 32'h0},
            '{0, 32'h8000_0000, 32'h0,         4'h0, 0, 0, 0, 32'h5A5A_5A5A},
            '{1, 32'h8000_0FFC, 32'h1234_5678, 4'hF, 1, 1, 0, 32'd1},
            '{0, 32'h8000_0FFF, 32'h0,         4'h0, 0, 0, 0, 32'h1234_5678},
            '{1, 32'h7FFF_FFFC, 32'hFFFF_FFFF, 4'hF, 0, 0, 0, 32'd0},
            '{0, 32'h7FFF_FFFC, 32'h0,         4'h0, 0, 0, 0, 32'h0},
            '{0, 32'h8000_0FFC, 32'h0,         4'h0, 0, 0, 0, 32'h1234_5678},
            '{1, 32'h8000_0010, 32'hFFFF_FFFF, 4'h0, 0, 0, 0, 32'd1},
            '{0, 32'h8000_0010, 32'h0,         4'h0, 0, 0, 5, 32'hCAFE_F00D}
        };

        reset        = 1'b1;
        bus.ar_valid = 1'b0;
        bus.ar_addr  = '0;
        bus.ar_prot  = '0;
        bus.aw_valid = 1'b0;
        bus.aw_addr  = '0;
        bus.aw_prot  = '0;
        bus.wd_valid = 1'b0;
        bus.wd_data  = '0;
        bus.wstrb    = '0;
        bus.rd_ready = 1'b1;
        bus.wr_ready = 1'b1;
        repeat (3) tick();
        reset = 1'b0;
        @(negedge aclk);
        check("rst_rd_valid", {31'b0, bus.rd_valid}, 32'd0);
        check("rst_rd_data", bus.rd_data, 32'd0);
        check("rst_wr_valid", {31'b0, bus.wr_valid}, 32'd0);
        check("rst_wr_breap", {31'b0, bus.wr_breap}, 32'd0);
        check("rst_ar_ready", {31'b0, bus.ar_ready}, 32'd1);
        check("rst_aw_ready", {31'b0, bus.aw_ready}, 32'd1);
        check("rst_wd_ready", {31'b0, bus.wd_ready}, 32'd1);
        tick();

        foreach (vt[i]) begin
            if (vt[i].wr) do_write(vt[i].addr, vt[i].data, vt[i].strb, vt[i].aw_d, vt[i].wd_d, vt[i].exp);
            else          do_read(vt[i].addr, vt[i].exp, vt[i].hold);
        end

        split_write(32'h8000_0030, 32'h0A0B_0C0D, 1'b1);
        do_read(32'h8000_0030, 32'h0A0B_0C0D, 0);
        split_write(32'h8000_0034, 32'h1020_3040, 1'b0);
        do_read(32'h8000_0034, 32'h1020_3040, 0);

        // Simultaneous ar and aw/wd in IDLE: write first, then read sees new data.
        wq.push_back(32'd1);
        rq.push_back(32'h1357_2468);
        bus.aw_valid = 1'b1;
        bus.aw_addr  = 32'h8000_0050;
        bus.wd_valid = 1'b1;
        bus.wd_data  = 32'h1357_2468;
        bus.wstrb    = 4'hF;
        bus.ar_valid = 1'b1;
        bus.ar_addr  = 32'h8000_0050;
        @(negedge aclk);
        check("prio_ar_ready", {31'b0, bus.ar_ready}, 32'd0);
        check("prio_aw_ready", {31'b0, bus.aw_ready}, 32'd1);
        tick();
        bus.aw_valid = 1'b0;
        bus.wd_valid = 1'b0;
        @(negedge aclk);
        check("prio_wr_first", {31'b0, bus.wr_valid}, 32'd1);
        check("prio_rd_later", {31'b0, bus.rd_valid}, 32'd0);
        tick();
        @(negedge aclk);
        check("prio_ar_after", {31'b0, bus.ar_ready}, 32'd1);
        tick();
        bus.ar_valid = 1'b0;
        @(negedge aclk);
        check("prio_rd_valid", {31'b0, bus.rd_valid}, 32'd1);
        tick();

        // Reset while WCOLLECT holds only the address; wd arrives during reset.
        do_write(32'h8000_0040, 32'h0BAD_F00D, 4'hF, 0, 0, 32'd1);
        bus.aw_valid = 1'b1;
        bus.aw_addr  = 32'h8000_0040;
        tick();
        bus.aw_valid = 1'b0;
        bus.wd_valid = 1'b1;
        bus.wd_data  = 32'hFFFF_FFFF;
        bus.wstrb    = 4'hF;
        reset        = 1'b1;
        tick();
        reset        = 1'b0;
        bus.wd_valid = 1'b0;
        @(negedge aclk);
        check("mrst_rd_valid", {31'b0, bus.rd_valid}, 32'd0);
        check("mrst_wr_valid", {31'b0, bus.wr_valid}, 32'd0);
        check("mrst_idle", {31'b0, bus.ar_ready}, 32'd1);
        tick();
        do_write(32'h8000_0044, 32'h0000_0077, 4'hF, 2, 0, 32'd1);
        do_read(32'h8000_0040, 32'h0BAD_F00D, 0);
        do_read(32'h8000_0044, 32'h0000_0077, 0);

        repeat (5) tick();
        check("rq_drained", rq.size(), 32'd0);
        check("wq_drained", wq.size(), 32'd0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
